excitation_injector: RTL

EXCITATION_INJECTOR -- requirements
Module: excitation_injector

---
 rtl/excitation_injector.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/excitation_injector.sv
// Scales a per-frame excitation sample by a Q2.14 gain and injects it as an external force into
// one target mass of the streaming mass pipeline. Define EXCITE_SPREAD_EN to also feed half the
// force into the two neighbouring masses.
module excitation_injector #(
  parameter int unsigned MASS_IDX_W = 8,
  parameter int unsigned GAIN_FRAC  = 14
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sample_tick,
  input  logic signed [26:0]    exc_in,
  input  logic        [15:0]    gain,
  input  logic [MASS_IDX_W-1:0] target_idx,
  input  logic                  mass_valid,
  input  logic [MASS_IDX_W-1:0] mass_idx,
  output logic                  force_valid,
  output logic signed [26:0]    force_out,
  output logic                  busy,
  output logic                  sat_flag,
  output logic                  timing_err
);

  typedef enum logic [2:0] {StIdle, StCapture, StMul, StSat, StArmed} state_e;

  localparam logic signed [42:0] ForceMax = 43'sd67108863;
  localparam logic signed [42:0] ForceMin = -43'sd67108864;

  state_e state_q, state_d;

  logic signed [26:0]    exc_q;
  logic        [15:0]    gain_q;
  logic [MASS_IDX_W-1:0] target_q;
  logic signed [42:0]    product_q;
  logic signed [26:0]    force_q;
  logic                  served_q;
  logic                  sat_q;
  logic                  terr_q;
  logic                  fvalid_q;
  logic signed [26:0]    fout_q;

  logic                  busy_st;
  logic                  armed;
  logic                  latch;
  logic signed [42:0]    exc_ext;
  logic signed [42:0]    gain_ext;
  logic signed [42:0]    shifted;
  logic signed [26:0]    clamped;
  logic                  clamp_hit;
  logic                  hit_c;
  logic signed [26:0]    force_d;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StArmed: if (sample_tick) state_d = StCapture;
      StCapture:       state_d = StMul;
      StMul:           state_d = StSat;
      StSat:           state_d = StArmed;
      default:         state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  assign busy_st = (state_q == StCapture) || (state_q == StMul) || (state_q == StSat);
  assign armed   = (state_q == StArmed);
  assign latch   = sample_tick && ((state_q == StIdle) || (state_q == StArmed));

  // Gain is unsigned, so it is zero-extended before the signed multiply.
  assign exc_ext  = {{16{exc_q[26]}}, exc_q};
  assign gain_ext = {27'b0, gain_q};
  assign shifted  = product_q >>> GAIN_FRAC;

  always_comb begin
    clamp_hit = 1'b0;
    clamped   = shifted[26:0];
    if (shifted > ForceMax) begin
      clamped   = ForceMax[26:0];
      clamp_hit = 1'b1;
    end else if (shifted < ForceMin) begin
      clamped   = ForceMin[26:0];
      clamp_hit = 1'b1;
    end
  end

  assign hit_c = armed && mass_valid && (mass_idx == target_q) && !served_q;

`ifdef EXCITE_SPREAD_EN
  localparam logic [MASS_IDX_W-1:0] IdxOne = 1;

  logic               served_lo_q;
  logic               served_hi_q;
  logic               hit_lo;
  logic               hit_hi;
  logic signed [26:0] force_half;

  // Neighbours exist only inside the index range; no wrap-around at either end.
  assign hit_lo = armed && mass_valid && (target_q != '0) &&
                  (mass_idx == target_q - IdxOne) && !served_lo_q;
  assign hit_hi = armed && mass_valid && (target_q != '1) &&
                  (mass_idx == target_q + IdxOne) && !served_hi_q;
  assign force_half = force_q >>> 1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      served_lo_q <= 1'b0;
      served_hi_q <= 1'b0;
    end else if (latch) begin
      served_lo_q <= 1'b0;
      served_hi_q <= 1'b0;
    end else begin
      if (hit_lo) served_lo_q <= 1'b1;
      if (hit_hi) served_hi_q <= 1'b1;
    end
  end
`endif

  always_comb begin
    force_d = '0;
    if (hit_c) begin
      force_d = force_q;
    end
`ifdef EXCITE_SPREAD_EN
    else if (hit_lo || hit_hi) begin
      force_d = force_half;
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      exc_q     <= '0;
      gain_q    <= '0;
      target_q  <= '0;
      product_q <= '0;
      force_q   <= '0;
      served_q  <= 1'b0;
      sat_q     <= 1'b0;
      terr_q    <= 1'b0;
      fvalid_q  <= 1'b0;
      fout_q    <= '0;
    end else begin
      if (latch) begin
        exc_q    <= exc_in;
        gain_q   <= gain;
        target_q <= target_idx;
      end
      if (state_q == StMul) begin
        product_q <= exc_ext * gain_ext;
      end
      if (state_q == StSat) begin
        force_q <= clamped;
        if (clamp_hit) sat_q <= 1'b1;
      end
      // Masses or ticks arriving while the frame is still being computed are lost.
      if (busy_st && (mass_valid || sample_tick)) begin
        terr_q <= 1'b1;
      end
      if (latch) begin
        served_q <= 1'b0;
      end else if (hit_c) begin
        served_q <= 1'b1;
      end
      fvalid_q <= mass_valid;
      fout_q   <= force_d;
    end
  end

  assign force_valid = fvalid_q;
  assign force_out   = fout_q;
  assign busy        = busy_st;
  assign sat_flag    = sat_q;
  assign timing_err  = terr_q;

endmodule
